fifo_spram_2bank: RTL and testbench

FIFO_SPRAM_2BANK -- requirements
Module: fifo_spram_2bank

---
 rtl/fifo_spram_2bank.sv | 139 +++++++++++++
 tb/tb_fifo_spram_2bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_spram_2bank.sv
// FIFO over two single-port RAM banks (even/odd entries) with a one-entry pending write buffer and a registered output stage.
// Latency: write to rd_valid is 2 cycles, or 3 when the write collides with a same-bank read and is parked in pending.
// Backpressure: wr_ready drops once FIFO_DEPTH slots are in use; rd_valid/rd_data hold while rd_ready is low.
module fifo_spram_2bank #(
    parameter int  DATA_WIDTH = 8,
    parameter int  FIFO_DEPTH = 16,
    parameter int  AF_LEVEL   = FIFO_DEPTH - 2,
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  almost_full
);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int BW         = AW - 1;
    localparam int BANK_DEPTH = FIFO_DEPTH / 2;

    // wr_ptr counts every accepted entry (pending one included); rd_ptr counts RAM reads issued.
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic                   pend_vld;
    logic                   pend_bank;
    logic [BW-1:0]          pend_addr;
    logic [DATA_WIDTH-1:0]  pend_dat;
    logic                   rd_vld_q;
    logic                   rd_sel;
    logic [CNT_WIDTH-1:0]   count_q;

    logic [AW:0]            slots_used;
    logic [AW:0]            committed;
    logic [AW:0]            slots_nxt;
    logic                   full;
    logic                   act;
    logic                   wr_acc;
    logic                   rd_issue;
    logic                   wr_collide;
    logic                   wr_direct;
    logic                   rd_vld_nxt;
    logic                   rd_bank;
    logic                   wr_bank;
    logic [BW-1:0]          rd_addr;
    logic [BW-1:0]          wr_addr;
    logic [CNT_WIDTH-1:0]   count_nxt;

    // Occupancy, handshakes and per-cycle bank arbitration
    always_comb begin
        slots_used = wr_ptr - rd_ptr;
        committed  = slots_used - {{AW{1'b0}}, pend_vld};
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        act        = rst_n && !flush;
        wr_acc     = wr_valid && !full;
        rd_bank    = rd_ptr[0];
        rd_addr    = rd_ptr[AW-1:1];
        wr_bank    = wr_ptr[0];
        wr_addr    = wr_ptr[AW-1:1];
        // A pending write owns its bank this cycle, so a read there must wait.
        rd_issue   = act && (committed != '0) && (!rd_vld_q || rd_ready)
                     && !(pend_vld && (pend_bank == rd_bank));
        // The pending entry always sits in the other bank from wr_ptr, so only a read can block a new write.
        wr_collide = rd_issue && (rd_bank == wr_bank);
        wr_direct  = act && wr_acc && !wr_collide;
        rd_vld_nxt = rd_issue || (rd_vld_q && !rd_ready);
        slots_nxt  = slots_used + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_issue};
        count_nxt  = CNT_WIDTH'(slots_nxt) + CNT_WIDTH'(rd_vld_nxt);
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic BSEL = (b == 1);
        logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] q;
        logic                  pend_hit;
        logic                  we;
        logic                  re;
        logic [BW-1:0]         wa;
        logic [DATA_WIDTH-1:0] wd;

        assign pend_hit = act && pend_vld && (pend_bank == BSEL);
        assign we       = pend_hit || (wr_direct && (wr_bank == BSEL));
        assign wa       = pend_hit ? pend_addr : wr_addr;
        assign wd       = pend_hit ? pend_dat : wr_data;
        assign re       = rd_issue && (rd_bank == BSEL);

        // Single port: one write or one read per cycle; q only changes on a read
        always_ff @(posedge clk) begin
            if (we) begin
                mem[wa] <= wd;
            end else if (re) begin
                q <= mem[rd_addr];
            end
        end
    end

    // Pointers, pending flag, output-stage valid/select and registered count
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend_vld <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_sel   <= 1'b0;
            count_q  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                rd_sel <= rd_bank;
            end
            pend_vld <= wr_acc && wr_collide;
            rd_vld_q <= rd_vld_nxt;
            count_q  <= count_nxt;
        end
    end

    // Pending payload is qualified by pend_vld, so it carries no reset
    always_ff @(posedge clk) begin
        if (wr_acc && wr_collide) begin
            pend_dat  <= wr_data;
            pend_bank <= wr_bank;
            pend_addr <= wr_addr;
        end
    end

    assign wr_ready    = !full;
    assign rd_valid    = rd_vld_q;
    assign rd_data     = rd_vld_q ? (rd_sel ? g_bank[1].q : g_bank[0].q) : '0;
    assign count       = count_q;
    assign almost_full = (count_q >= CNT_WIDTH'(AF_LEVEL));

endmodule

// File: tb/tb_fifo_spram_2bank.sv
// Directed-vector and reference-queue bench for the two-bank SPRAM FIFO.
// Inputs change 1 time unit after the rising edge; outputs are sampled then or at the falling edge.
// A queue model tracks accepted/popped entries for data-order and count checks.
module tb_fifo_spram_2bank;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 2);

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          flush    = 1'b0;
    logic          wr_valid = 1'b0;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;
    logic          almost_full;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model_q[$];

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       e_rv;
        logic       chk_rd;
        logic [7:0] e_rd;
        logic [4:0] e_cnt;
        logic       e_wr;
        logic       e_af;
    } vec_t;

    fifo_spram_2bank #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock with the current inputs; the model follows the handshakes seen at the falling edge.
    task automatic tick();
        logic acc;
        logic pp;
        @(negedge clk);
        acc = wr_valid && wr_ready;
        pp  = rd_valid && rd_ready;
        if (!rst_n || flush) begin
            model_q.delete();
        end else begin
            if (pp) begin
                if (model_q.size() == 0) check("pop_unexpected", rd_valid, 0);
                else check("pop_data", rd_data, model_q.pop_front());
            end
            if (acc) model_q.push_back(wr_data);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rr,
                                input logic e_rv, input logic chk_rd, input logic [7:0] e_rd,
                                input logic [4:0] e_cnt, input logic e_wr, input logic e_af);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rr = rr;
        v.e_rv = e_rv; v.chk_rd = chk_rd; v.e_rd = e_rd;
        v.e_cnt = e_cnt; v.e_wr = e_wr; v.e_af = e_af;
        return v;
    endfunction

    // Prefill three entries so the steady stream collides every cycle and uses the pending buffer.
    task automatic stream(input int n);
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'(i + 1);
            tick();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            wr_data = 8'(i + 4);
            check("stream_no_gap", rd_valid, 1);
            tick();
            check("stream_count", count, 3);
        end
    endtask

    task automatic after_clear(input string tag);
        check({tag, " count"}, count, 0);
        check({tag, " rd_valid"}, rd_valid, 0);
        check({tag, " wr_ready"}, wr_ready, 1);
        check({tag, " almost_full"}, almost_full, 0);
        wr_valid = 1'b1; wr_data = 8'h3C; rd_ready = 1'b0;
        tick();
        wr_valid = 1'b0;
        tick();
        check({tag, " first rd_valid"}, rd_valid, 1);
        check({tag, " first rd_data"}, rd_data, 8'h3C);
        check({tag, " first count"}, count, 1);
        rd_ready = 1'b1;
        tick();
        check({tag, " empty rd_valid"}, rd_valid, 0);
        check({tag, " empty count"}, count, 0);
        rd_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        int   guard;

        // Directed table: reset state, single write latency, fill to full, stalled extra write
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 5'd0, 1, 0));
        vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 8'h00, 5'd1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 8'hA5, 5'd1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 5'd0, 1, 0));
        for (int k = 1; k <= 17; k++)
            vecs.push_back(mk(1, 8'(k), 0, k >= 2, k >= 2, 8'h01, 5'(k), k <= 16, k >= 14));
        vecs.push_back(mk(1, 8'h12, 0, 1, 1, 8'h01, 5'd17, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            rd_ready = vecs[i].rr;
            tick();
            check($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].e_rv);
            if (vecs[i].chk_rd) check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].e_rd);
            check($sformatf("vec%0d count", i), count, vecs[i].e_cnt);
            check($sformatf("vec%0d wr_ready", i), wr_ready, vecs[i].e_wr);
            check($sformatf("vec%0d almost_full", i), almost_full, vecs[i].e_af);
        end

        // Drain the full FIFO: 0x01..0x11 back to back, the stalled 0x12 never appears
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            check($sformatf("drain%0d rd_valid", i), rd_valid, 1);
            check($sformatf("drain%0d rd_data", i), rd_data, 8'(i));
            tick();
        end
        check("drained rd_valid", rd_valid, 0);
        check("drained count", count, 0);
        check("drained wr_ready", wr_ready, 1);

        // Sustained write+pop, then flush with pending and output stage both occupied
        stream(1000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        after_clear("flush");

        // Same situation cleared by reset instead
        stream(20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("reset rd_data", rd_data, 0);
        after_clear("reset");

        // Random traffic against the reference queue
        for (int i = 0; i < 10000; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            rd_ready = 1'($urandom_range(0, 1));
            wr_data  = 8'($urandom);
            tick();
            check("rand_count", count, model_q.size());
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        guard = 0;
        while ((rd_valid || model_q.size() != 0) && guard < 64) begin
            tick();
            guard++;
        end
        check("rand_drain rd_valid", rd_valid, 0);
        check("rand_drain count", count, 0);
        check("rand_drain model_left", model_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
